// File: rtl/mb_dp_bram_ctrl.sv
// mb_dp_bram_ctrl: true dual-port MicroBlaze LMB local memory with optional zero-fill after reset.
// Latency: read data lands on BRAM_Din_x C_READ_LATENCY (1 or 2) cycles after the access edge.
// Backpressure: none; both ports are ignored (no writes, Din held at 0) until Init_Done is high.
//
// Bit order: MicroBlaze bit 0 is the MSB. Vectors here are declared [W-1:0], so MicroBlaze
// byte [0:7] is data[W-1 -: 8] and its enable is the leftmost WEN bit, i.e. WEN[j] <-> data[8j +: 8].
module mb_dp_bram_ctrl #(
  parameter int    C_MEMSIZE      = 'h4000,
  parameter int    C_PORT_DWIDTH  = 32,
  parameter int    C_PORT_AWIDTH  = 32,
  parameter int    C_NUM_WE       = 4,
  parameter int    C_READ_LATENCY = 1,
  parameter string C_WRITE_MODE_A = "READ_FIRST",
  parameter string C_WRITE_MODE_B = "READ_FIRST",
  parameter int    C_INIT_ZERO    = 1
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst,
  input  logic                     BRAM_EN_A,
  input  logic [C_NUM_WE-1:0]      BRAM_WEN_A,
  input  logic [C_PORT_AWIDTH-1:0] BRAM_Addr_A,
  input  logic [C_PORT_DWIDTH-1:0] BRAM_Dout_A,
  output logic [C_PORT_DWIDTH-1:0] BRAM_Din_A,
  input  logic                     BRAM_EN_B,
  input  logic [C_NUM_WE-1:0]      BRAM_WEN_B,
  input  logic [C_PORT_AWIDTH-1:0] BRAM_Addr_B,
  input  logic [C_PORT_DWIDTH-1:0] BRAM_Dout_B,
  output logic [C_PORT_DWIDTH-1:0] BRAM_Din_B,
  output logic                     Init_Done,
  output logic                     Collision,
  output logic [15:0]              Collision_Cnt
);

  localparam int DEPTH = C_MEMSIZE / C_NUM_WE;
  localparam int AW    = $clog2(DEPTH);
  localparam int BO    = $clog2(C_NUM_WE);
  localparam bit WF_A  = (C_WRITE_MODE_A == "WRITE_FIRST");
  localparam bit WF_B  = (C_WRITE_MODE_B == "WRITE_FIRST");

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [C_PORT_DWIDTH-1:0] r_mem [DEPTH];

  logic [1:0]               r_state;
  logic [AW-1:0]            r_fill_idx;
  logic                     r_coll;
  logic [15:0]              r_coll_cnt;
  logic                     r_vld1_a, r_vld1_b;
  logic [C_PORT_DWIDTH-1:0] r_rd1_a, r_rd1_b, r_rd2_a, r_rd2_b;

  logic                     w_ready, w_fill;
  logic                     w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_same, w_coll;
  logic [AW-1:0]            w_idx_a, w_idx_b;
  logic [C_PORT_DWIDTH-1:0] w_mask_a, w_mask_b;
  logic [C_PORT_DWIDTH-1:0] w_old_a, w_old_b, w_merge_a, w_merge_b;
  logic [C_PORT_DWIDTH-1:0] w_base_a, w_wdat_a, w_rd_a, w_rd_b;
  logic                     w_unused;

  // High address bits and the byte offset are don't-care: the memory aliases every C_MEMSIZE bytes.
  assign w_unused = ^{BRAM_Addr_A, BRAM_Addr_B};

  assign w_ready = (r_state == ST_READY);
  assign w_fill  = (r_state == ST_FILL) & ~BRAM_Rst;
  assign w_acc_a = BRAM_EN_A & w_ready & ~BRAM_Rst;
  assign w_acc_b = BRAM_EN_B & w_ready & ~BRAM_Rst;
  assign w_wr_a  = |BRAM_WEN_A;
  assign w_wr_b  = |BRAM_WEN_B;
  assign w_idx_a = BRAM_Addr_A[BO +: AW];
  assign w_idx_b = BRAM_Addr_B[BO +: AW];
  assign w_same  = (w_idx_a == w_idx_b);
  assign w_coll  = w_acc_a & w_acc_b & w_same & (w_wr_a | w_wr_b);

  assign w_old_a = r_mem[w_idx_a];
  assign w_old_b = r_mem[w_idx_b];

  // Expand byte enables into bit masks.
  always_comb begin
    w_mask_a = '0;
    w_mask_b = '0;
    for (int j = 0; j < C_NUM_WE; j++) begin
      w_mask_a[8*j +: 8] = {8{BRAM_WEN_A[j]}};
      w_mask_b[8*j +: 8] = {8{BRAM_WEN_B[j]}};
    end
  end

  // Own-port merge: written bytes new, unwritten bytes old (also the WRITE_FIRST read value).
  assign w_merge_a = (w_old_a & ~w_mask_a) | (BRAM_Dout_A & w_mask_a);
  assign w_merge_b = (w_old_b & ~w_mask_b) | (BRAM_Dout_B & w_mask_b);

  // When both ports write the same word, A layers its bytes over B's result so A wins overlaps.
  assign w_base_a = (w_acc_b & w_wr_b & w_same) ? w_merge_b : w_old_a;
  assign w_wdat_a = (w_base_a & ~w_mask_a) | (BRAM_Dout_A & w_mask_a);

  // A cross-port reader always sees the pre-edge word since its own mask is empty.
  assign w_rd_a = WF_A ? w_merge_a : w_old_a;
  assign w_rd_b = WF_B ? w_merge_b : w_old_b;

  // Memory array: zero-fill, then port B, then port A (later assignment wins on the same word).
  always_ff @(posedge BRAM_Clk) begin
    if (w_fill) begin
      r_mem[r_fill_idx] <= '0;
    end
    if (w_acc_b && w_wr_b) begin
      r_mem[w_idx_b] <= w_merge_b;
    end
    if (w_acc_a && w_wr_a) begin
      r_mem[w_idx_a] <= w_wdat_a;
    end
  end

  // Init sequencer: RESET -> FILL (one word per cycle) -> READY, or straight to READY.
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      r_state    <= ST_RESET;
      r_fill_idx <= '0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_fill_idx <= '0;
          r_state    <= (C_INIT_ZERO != 0) ? ST_FILL : ST_READY;
        end
        ST_FILL: begin
          r_fill_idx <= r_fill_idx + 1'b1;
          if (r_fill_idx == AW'(DEPTH - 1)) begin
            r_state <= ST_READY;
          end
        end
        ST_READY: r_state <= ST_READY;
        default:  r_state <= ST_RESET;
      endcase
    end
  end

  // Collision pulse and saturating counter.
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      r_coll <= w_coll;
      if (w_coll && (r_coll_cnt != 16'hFFFF)) begin
        r_coll_cnt <= r_coll_cnt + 16'd1;
      end
    end
  end

  // Read pipeline: stage 1 captures on access; stage 2 advances only behind a valid stage 1.
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      r_vld1_a <= 1'b0;
      r_vld1_b <= 1'b0;
      r_rd1_a  <= '0;
      r_rd1_b  <= '0;
      r_rd2_a  <= '0;
      r_rd2_b  <= '0;
    end else begin
      r_vld1_a <= w_acc_a;
      r_vld1_b <= w_acc_b;
      if (w_acc_a) r_rd1_a <= w_rd_a;
      if (w_acc_b) r_rd1_b <= w_rd_b;
      if (r_vld1_a) r_rd2_a <= r_rd1_a;
      if (r_vld1_b) r_rd2_b <= r_rd1_b;
    end
  end

  assign BRAM_Din_A    = (C_READ_LATENCY == 2) ? r_rd2_a : r_rd1_a;
  assign BRAM_Din_B    = (C_READ_LATENCY == 2) ? r_rd2_b : r_rd1_b;
  assign Init_Done     = w_ready;
  assign Collision     = r_coll;
  assign Collision_Cnt = r_coll_cnt;

endmodule

// File: tb/tb_mb_dp_bram_ctrl.sv
// Bench for mb_dp_bram_ctrl: instance 0 uses defaults (16 KB, latency 1, read-first);
// instance 1 is 256 B, latency 2, port A write-first. A reference model runs beside both.
module tb_mb_dp_bram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        en_a     [2];
  logic        en_b     [2];
  logic [3:0]  wen_a    [2];
  logic [3:0]  wen_b    [2];
  logic [31:0] addr_a   [2];
  logic [31:0] addr_b   [2];
  logic [31:0] dout_a   [2];
  logic [31:0] dout_b   [2];
  logic [31:0] din_a    [2];
  logic [31:0] din_b    [2];
  logic        init_done[2];
  logic        coll     [2];
  logic [15:0] ccnt     [2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [31:0] mem_m   [2][4096];
  bit          ready_m [2];
  int          fillc_m [2];
  logic [31:0] exp_a   [2];
  logic [31:0] exp_b   [2];
  logic [31:0] s1_a    [2];
  logic [31:0] s1_b    [2];
  bit          s1v_a   [2];
  bit          s1v_b   [2];
  logic        exp_coll[2];
  logic [15:0] exp_cnt [2];

  mb_dp_bram_ctrl u_dut0 (
    .BRAM_Clk(clk), .BRAM_Rst(rst[0]),
    .BRAM_EN_A(en_a[0]), .BRAM_WEN_A(wen_a[0]), .BRAM_Addr_A(addr_a[0]),
    .BRAM_Dout_A(dout_a[0]), .BRAM_Din_A(din_a[0]),
    .BRAM_EN_B(en_b[0]), .BRAM_WEN_B(wen_b[0]), .BRAM_Addr_B(addr_b[0]),
    .BRAM_Dout_B(dout_b[0]), .BRAM_Din_B(din_b[0]),
    .Init_Done(init_done[0]), .Collision(coll[0]), .Collision_Cnt(ccnt[0])
  );

  mb_dp_bram_ctrl #(
    .C_MEMSIZE('h100), .C_READ_LATENCY(2), .C_WRITE_MODE_A("WRITE_FIRST")
  ) u_dut1 (
    .BRAM_Clk(clk), .BRAM_Rst(rst[1]),
    .BRAM_EN_A(en_a[1]), .BRAM_WEN_A(wen_a[1]), .BRAM_Addr_A(addr_a[1]),
    .BRAM_Dout_A(dout_a[1]), .BRAM_Din_A(din_a[1]),
    .BRAM_EN_B(en_b[1]), .BRAM_WEN_B(wen_b[1]), .BRAM_Addr_B(addr_b[1]),
    .BRAM_Dout_B(dout_b[1]), .BRAM_Din_B(din_b[1]),
    .Init_Done(init_done[1]), .Collision(coll[1]), .Collision_Cnt(ccnt[1])
  );

  function automatic int depth_of(input int k);
    return (k == 0) ? 4096 : 64;
  endfunction

  // Byte lane j of the word takes byte j of dat when enable bit j is set.
  function automatic logic [31:0] put_bytes(input logic [31:0] old, input logic [31:0] dat,
                                            input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int j = 0; j < 4; j++) if (wen[j]) r[8*j +: 8] = dat[8*j +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the specification's rules for one clock edge of instance k.
  task automatic model_edge(input int k);
    int d, ia, ib;
    bit aa, ab;
    logic [31:0] ra, rb;
    d = depth_of(k);
    if (rst[k]) begin
      ready_m[k] = 1'b0; fillc_m[k] = 0;
      exp_a[k] = '0; exp_b[k] = '0; s1_a[k] = '0; s1_b[k] = '0;
      s1v_a[k] = 1'b0; s1v_b[k] = 1'b0; exp_coll[k] = 1'b0; exp_cnt[k] = '0;
      return;
    end
    aa = en_a[k] && ready_m[k];
    ab = en_b[k] && ready_m[k];
    ia = int'((addr_a[k] % (32'(d) * 32'd4)) / 32'd4);
    ib = int'((addr_b[k] % (32'(d) * 32'd4)) / 32'd4);
    ra = mem_m[k][ia];
    rb = mem_m[k][ib];
    if (k == 1) ra = put_bytes(ra, dout_a[k], wen_a[k]);
    exp_coll[k] = aa && ab && (ia == ib) && (wen_a[k] != 0 || wen_b[k] != 0);
    if (exp_coll[k] && exp_cnt[k] != 16'hFFFF) exp_cnt[k] = exp_cnt[k] + 16'd1;
    if (ab) mem_m[k][ib] = put_bytes(mem_m[k][ib], dout_b[k], wen_b[k]);
    if (aa) mem_m[k][ia] = put_bytes(mem_m[k][ia], dout_a[k], wen_a[k]);
    if (k == 0) begin
      if (aa) exp_a[k] = ra;
      if (ab) exp_b[k] = rb;
    end else begin
      if (s1v_a[k]) exp_a[k] = s1_a[k];
      if (s1v_b[k]) exp_b[k] = s1_b[k];
      s1v_a[k] = aa; s1v_b[k] = ab;
      if (aa) s1_a[k] = ra;
      if (ab) s1_b[k] = rb;
    end
    if (!ready_m[k]) begin
      fillc_m[k]++;
      if (fillc_m[k] == d + 1) begin
        ready_m[k] = 1'b1;
        for (int i = 0; i < d; i++) mem_m[k][i] = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("din_a%0d", k), din_a[k], exp_a[k]);
        chk($sformatf("din_b%0d", k), din_b[k], exp_b[k]);
        chk($sformatf("init%0d", k), 32'(init_done[k]), 32'(ready_m[k]));
        chk($sformatf("coll%0d", k), 32'(coll[k]), 32'(exp_coll[k]));
        chk($sformatf("cnt%0d", k), 32'(ccnt[k]), 32'(exp_cnt[k]));
      end
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      en_a[k] = 1'b0; en_b[k] = 1'b0; wen_a[k] = '0; wen_b[k] = '0;
    end
  endtask

  task automatic set_a(input int k, input logic [3:0] w, input logic [31:0] ad, input logic [31:0] d);
    en_a[k] = 1'b1; wen_a[k] = w; addr_a[k] = ad; dout_a[k] = d;
  endtask

  task automatic set_b(input int k, input logic [3:0] w, input logic [31:0] ad, input logic [31:0] d);
    en_b[k] = 1'b1; wen_b[k] = w; addr_b[k] = ad; dout_b[k] = d;
  endtask

  // Count cycles with Init_Done low on instance 0 until it rises (bounded).
  task automatic wait_fill(output int n);
    n = 0;
    do begin
      tick();
      if (init_done[0] !== 1'b1) n++;
    end while (init_done[0] !== 1'b1 && n < 5000);
  endtask

  int n;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; addr_a[k] = '0; addr_b[k] = '0; dout_a[k] = '0; dout_b[k] = '0;
    end
    idle();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_din_a", din_a[k], 32'h0);
      chk("rst_din_b", din_b[k], 32'h0);
      chk("rst_init", 32'(init_done[k]), 32'h0);
      chk("rst_coll", 32'(coll[k]), 32'h0);
      chk("rst_cnt", 32'(ccnt[k]), 32'h0);
    end
    chk_en = 1'b1;

    // Zero-fill after reset: 4096 low cycles, then high.
    rst[0] = 1'b0; rst[1] = 1'b0;
    wait_fill(n);
    chk("fill_len", 32'(n), 32'd4096);

    set_a(0, 4'h0, 32'h3FFC, 32'h0); tick(); idle();
    chk("rd_3ffc", din_a[0], 32'h0);

    // Byte-enable merge and aliasing.
    set_a(0, 4'hF, 32'h10, 32'hAABBCCDD); tick(); idle();
    set_b(0, 4'h3, 32'h10, 32'h11223344); tick(); idle();
    set_a(0, 4'h0, 32'h10, 32'h0); set_b(0, 4'h0, 32'h4010, 32'h0); tick(); idle();
    chk("merge_a", din_a[0], 32'hAABB3344);
    chk("alias_b", din_b[0], 32'hAABB3344);
    chk("rdrd_nocoll", 32'(coll[0]), 32'h0);

    // Both ports write the same word.
    set_a(0, 4'hC, 32'h20, 32'h12345678); set_b(0, 4'h6, 32'h20, 32'h9ABCDEF0); tick(); idle();
    chk("ww_coll", 32'(coll[0]), 32'h1);
    chk("ww_cnt", 32'(ccnt[0]), 32'h1);
    set_a(0, 4'h0, 32'h20, 32'h0); tick(); idle();
    chk("ww_pulse_end", 32'(coll[0]), 32'h0);
    chk("ww_data", din_a[0], 32'h1234DE00);

    // Write on A, read on B, same word: reader gets the old word.
    set_a(0, 4'hF, 32'h30, 32'hFFFFFFFF); set_b(0, 4'h0, 32'h30, 32'h0);
    set_a(1, 4'hF, 32'h30, 32'hFFFFFFFF); set_b(1, 4'h0, 32'h30, 32'h0);
    tick(); idle();
    chk("rdw_old_b", din_b[0], 32'h0);
    chk("rdw_cnt", 32'(ccnt[0]), 32'h2);
    chk("lat2_not_yet", din_a[1], 32'h0);
    tick();
    chk("wf_own_a", din_a[1], 32'hFFFFFFFF);
    chk("wf_cross_b", din_b[1], 32'h0);
    chk("wf_cnt", 32'(ccnt[1]), 32'h1);
    set_b(0, 4'h0, 32'h30, 32'h0); tick(); idle();
    chk("rdw_after", din_b[0], 32'hFFFFFFFF);

    // Latency 2: back-to-back read stream, then hold on idle.
    for (int i = 0; i < 8; i++) begin
      set_a(1, 4'hF, 32'h40 + 32'(4*i), 32'hC0DE0000 + 32'(i)); tick(); idle();
    end
    for (int i = 0; i < 8; i++) begin
      set_a(1, 4'h0, 32'h40 + 32'(4*i), 32'h0); tick();
      if (i >= 1) chk("stream", din_a[1], 32'hC0DE0000 + 32'(i - 1));
    end
    idle(); tick();
    chk("stream_last", din_a[1], 32'hC0DE0007);
    tick();
    chk("idle_hold", din_a[1], 32'hC0DE0007);

    // Randomized traffic on a few words per instance to provoke collisions.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        en_a[k]   = 1'($urandom_range(0, 1));
        en_b[k]   = 1'($urandom_range(0, 1));
        wen_a[k]  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        wen_b[k]  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        addr_a[k] = $urandom & ((k == 0) ? ~32'h3FE0 : ~32'hE0);
        addr_b[k] = $urandom & ((k == 0) ? ~32'h3FE0 : ~32'hE0);
        dout_a[k] = $urandom;
        dout_b[k] = $urandom;
      end
      tick();
    end
    idle();

    // Reset clears the counter; a reset mid-fill restarts the fill from word 0.
    rst[0] = 1'b1; tick();
    chk("rst2_cnt", 32'(ccnt[0]), 32'h0);
    chk("rst2_din", din_a[0], 32'h0);
    rst[0] = 1'b0;
    repeat (1001) tick();
    rst[0] = 1'b1; tick();
    chk("midfill_init", 32'(init_done[0]), 32'h0);
    rst[0] = 1'b0;
    set_a(0, 4'hF, 32'h10, 32'hFFFFFFFF); set_b(0, 4'h0, 32'h10, 32'h0);
    wait_fill(n);
    idle();
    chk("refill_len", 32'(n), 32'd4096);
    chk("refill_nocnt", 32'(ccnt[0]), 32'h0);
    set_a(0, 4'h0, 32'h10, 32'h0); tick(); idle();
    chk("refill_zero", din_a[0], 32'h0);

    // Drive the counter to saturation.
    chk_en = 1'b0;
    set_a(0, 4'hF, 32'h0, 32'h5A5A5A5A); set_b(0, 4'h0, 32'h0, 32'h0);
    repeat (65534) tick();
    chk("cnt_fffe", 32'(ccnt[0]), 32'hFFFE);
    repeat (3) tick();
    chk("cnt_sat", 32'(ccnt[0]), 32'hFFFF);
    chk("cnt_sat_model", 32'(ccnt[0]), 32'(exp_cnt[0]));
    chk("sat_coll", 32'(coll[0]), 32'h1);
    idle(); tick();
    chk("sat_hold", 32'(ccnt[0]), 32'hFFFF);
    chk("sat_coll_end", 32'(coll[0]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
